// File: rtl/ghost_pkg.sv
// Shared types and constants for the ghost tile mover.
package ghost_pkg;

    localparam int unsigned MAZE_W  = 28;
    localparam int unsigned MAZE_H  = 31;
    localparam int unsigned COORD_W = 5;

    typedef logic [COORD_W-1:0] coord_t;

    // Direction encoding; the value doubles as the bit index in 4-bit direction vectors.
    typedef enum logic [1:0] {
        DIR_U = 2'd0,
        DIR_R = 2'd1,
        DIR_D = 2'd2,
        DIR_L = 2'd3
    } dir_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_U = 3'd1,
        ST_RD_R = 3'd2,
        ST_RD_D = 3'd3,
        ST_RD_L = 3'd4,
        ST_LAST = 3'd5,
        ST_STEP = 3'd6
    } state_t;

    localparam coord_t X_MAX = coord_t'(MAZE_W - 1);
    localparam coord_t Y_MAX = coord_t'(MAZE_H - 1);

    // Opposite heading: U<->D, R<->L (flip the upper encoding bit).
    function automatic dir_t reverse_dir(input dir_t d);
        return dir_t'(d ^ 2'b10);
    endfunction

    // Remove the way back unless it is the only way out.
    function automatic logic [3:0] mask_reverse(input logic [3:0] open_dirs, input dir_t last_dir);
        logic [1:0] rev_idx;
        logic [3:0] rev_bit;
        logic [3:0] others;
        rev_idx = reverse_dir(last_dir);
        rev_bit = 4'b0001 << rev_idx;
        others  = open_dirs & ~rev_bit;
        if (others != 4'b0000) begin
            return others;
        end else begin
            return open_dirs;
        end
    endfunction

endpackage

// File: rtl/ghost_mover_tile_neighbor.sv
// Combinational neighbour-tile calculator with maze clamping and tunnel wrap.
module tile_neighbor
    import ghost_pkg::*;
(
    input  coord_t x_i,
    input  coord_t y_i,
    input  dir_t   dir_i,
    input  coord_t tunnel_row_i,
    output coord_t nx_o,
    output coord_t ny_o,
    output logic   in_range_o
);

    // Neighbour coordinate; off-maze neighbours keep the current tile and flag out of range.
    always_comb begin
        nx_o       = x_i;
        ny_o       = y_i;
        in_range_o = 1'b1;
        case (dir_i)
            DIR_U: begin
                if (y_i == 5'd0) begin
                    in_range_o = 1'b0;
                end else begin
                    ny_o = y_i - 5'd1;
                end
            end
            DIR_R: begin
                if (x_i >= X_MAX) begin
                    if (y_i == tunnel_row_i) begin
                        nx_o = 5'd0;
                    end else begin
                        in_range_o = 1'b0;
                    end
                end else begin
                    nx_o = x_i + 5'd1;
                end
            end
            DIR_D: begin
                if (y_i >= Y_MAX) begin
                    in_range_o = 1'b0;
                end else begin
                    ny_o = y_i + 5'd1;
                end
            end
            DIR_L: begin
                if (x_i == 5'd0) begin
                    if (y_i == tunnel_row_i) begin
                        nx_o = X_MAX;
                    end else begin
                        in_range_o = 1'b0;
                    end
                end else begin
                    nx_o = x_i - 5'd1;
                end
            end
            default: begin
                in_range_o = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/ghost_mover.sv
// Ghost tile mover: queries the four neighbour walls, publishes move
// permissions, then steps one tile in the direction chosen by behaviour.
module ghost_mover
    import ghost_pkg::*;
#(
    parameter int unsigned START_X    = 13,
    parameter int unsigned START_Y    = 11,
    parameter logic [1:0]  START_DIR  = 2'd3,
    parameter int unsigned TUNNEL_ROW = 14
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       moveTick,
    input  logic [1:0] dirToMove,
    output logic       wallRdEn,
    output logic [4:0] wallAddrX,
    output logic [4:0] wallAddrY,
    input  logic       wallData,
    output logic       canMoveU,
    output logic       canMoveR,
    output logic       canMoveD,
    output logic       canMoveL,
    output logic [4:0] ghostPosX,
    output logic [4:0] ghostPosY,
    output logic       busy,
    output logic       stepDone
);

    state_t     state_q;
    coord_t     pos_x_q;
    coord_t     pos_y_q;
    dir_t       last_dir_q;
    logic [3:0] shadow_q;
    logic [3:0] shadow_d;
    logic [3:0] can_move_q;
    logic [3:0] can_move_d;
    logic       rd_en_q;
    coord_t     addr_x_q;
    coord_t     addr_y_q;
    logic       rd_in_range_q;
    logic       data_in_range_q;
    logic       busy_q;
    logic       step_done_q;

    dir_t       nb_dir_s;
    coord_t     nb_x_s;
    coord_t     nb_y_s;
    logic       nb_in_range_s;
    logic       wall_now_s;
    logic       move_ok_s;

    // Pick the direction fed to the shared neighbour calculator: next read, or the chosen move.
    always_comb begin
        nb_dir_s = DIR_U;
        case (state_q)
            ST_IDLE: nb_dir_s = DIR_U;
            ST_RD_U: nb_dir_s = DIR_R;
            ST_RD_R: nb_dir_s = DIR_D;
            ST_RD_D: nb_dir_s = DIR_L;
            ST_STEP: nb_dir_s = dir_t'(dirToMove);
            default: nb_dir_s = DIR_U;
        endcase
    end

    tile_neighbor u_nb (
        .x_i          (pos_x_q),
        .y_i          (pos_y_q),
        .dir_i        (nb_dir_s),
        .tunnel_row_i (coord_t'(TUNNEL_ROW)),
        .nx_o         (nb_x_s),
        .ny_o         (nb_y_s),
        .in_range_o   (nb_in_range_s)
    );

    // Returned data counts as a wall when the address was clamped off the maze.
    assign wall_now_s = ~data_in_range_q | wallData;

    // Shadow wall bits: each read result lands one state after its read strobe.
    always_comb begin
        shadow_d = shadow_q;
        case (state_q)
            ST_RD_R: shadow_d[0] = wall_now_s;
            ST_RD_D: shadow_d[1] = wall_now_s;
            ST_RD_L: shadow_d[2] = wall_now_s;
            ST_LAST: shadow_d[3] = wall_now_s;
            default: shadow_d = shadow_q;
        endcase
    end

    assign can_move_d = mask_reverse(~shadow_d, last_dir_q);
    assign move_ok_s  = can_move_q[dirToMove];

    // Query/step sequencer with all outputs registered.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= ST_IDLE;
            pos_x_q         <= coord_t'(START_X);
            pos_y_q         <= coord_t'(START_Y);
            last_dir_q      <= dir_t'(START_DIR);
            shadow_q        <= 4'b0000;
            can_move_q      <= 4'b0000;
            rd_en_q         <= 1'b0;
            addr_x_q        <= 5'd0;
            addr_y_q        <= 5'd0;
            rd_in_range_q   <= 1'b0;
            data_in_range_q <= 1'b0;
            busy_q          <= 1'b0;
            step_done_q     <= 1'b0;
        end else begin
            rd_en_q         <= 1'b0;
            addr_x_q        <= 5'd0;
            addr_y_q        <= 5'd0;
            rd_in_range_q   <= 1'b0;
            data_in_range_q <= rd_in_range_q;
            step_done_q     <= 1'b0;
            shadow_q        <= shadow_d;
            case (state_q)
                ST_IDLE: begin
                    if (moveTick) begin
                        state_q       <= ST_RD_U;
                        busy_q        <= 1'b1;
                        rd_en_q       <= 1'b1;
                        addr_x_q      <= nb_x_s;
                        addr_y_q      <= nb_y_s;
                        rd_in_range_q <= nb_in_range_s;
                    end else begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                ST_RD_U, ST_RD_R, ST_RD_D: begin
                    state_q       <= state_t'(state_q + 3'd1);
                    busy_q        <= 1'b1;
                    rd_en_q       <= 1'b1;
                    addr_x_q      <= nb_x_s;
                    addr_y_q      <= nb_y_s;
                    rd_in_range_q <= nb_in_range_s;
                end
                ST_RD_L: begin
                    state_q <= ST_LAST;
                    busy_q  <= 1'b1;
                end
                ST_LAST: begin
                    state_q     <= ST_STEP;
                    busy_q      <= 1'b1;
                    can_move_q  <= can_move_d;
                    step_done_q <= 1'b1;
                end
                ST_STEP: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                    if (move_ok_s) begin
                        pos_x_q    <= nb_x_s;
                        pos_y_q    <= nb_y_s;
                        last_dir_q <= dir_t'(dirToMove);
                    end else begin
                        pos_x_q    <= pos_x_q;
                        pos_y_q    <= pos_y_q;
                        last_dir_q <= last_dir_q;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wallRdEn  = rd_en_q;
    assign wallAddrX = addr_x_q;
    assign wallAddrY = addr_y_q;
    assign canMoveU  = can_move_q[0];
    assign canMoveR  = can_move_q[1];
    assign canMoveD  = can_move_q[2];
    assign canMoveL  = can_move_q[3];
    assign ghostPosX = pos_x_q;
    assign ghostPosY = pos_y_q;
    assign busy      = busy_q;
    assign stepDone  = step_done_q;

endmodule

// File: tb/tb_ghost_mover.sv
// Directed bench for ghost_mover with a small wall-memory model.
module tb_ghost_mover;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       moveTick = 1'b0;
    logic [1:0] dirToMove = 2'd0;
    logic       wallRdEn;
    logic [4:0] wallAddrX;
    logic [4:0] wallAddrY;
    logic       wallData = 1'b0;
    logic       canMoveU, canMoveR, canMoveD, canMoveL;
    logic [4:0] ghostPosX, ghostPosY;
    logic       busy, stepDone;

    int checks = 0;
    int errors = 0;

    logic maze [0:30][0:27];

    logic [4:0] rec_ax [0:7];
    logic [4:0] rec_ay [0:7];
    logic       rec_en [0:7];
    logic       rec_sd [0:7];
    logic       rec_bz [0:7];
    logic [3:0] rec_cm [0:7];
    logic [4:0] rec_px [0:7];
    logic [4:0] rec_py [0:7];

    ghost_mover dut (
        .clk       (clk),
        .reset     (reset),
        .moveTick  (moveTick),
        .dirToMove (dirToMove),
        .wallRdEn  (wallRdEn),
        .wallAddrX (wallAddrX),
        .wallAddrY (wallAddrY),
        .wallData  (wallData),
        .canMoveU  (canMoveU),
        .canMoveR  (canMoveR),
        .canMoveD  (canMoveD),
        .canMoveL  (canMoveL),
        .ghostPosX (ghostPosX),
        .ghostPosY (ghostPosY),
        .busy      (busy),
        .stepDone  (stepDone)
    );

    always #5 clk = ~clk;

    // Wall memory: one-cycle read latency.
    always @(posedge clk) begin
        if (wallRdEn && wallAddrY < 5'd31 && wallAddrX < 5'd28) begin
            wallData <= maze[wallAddrY][wallAddrX];
        end else begin
            wallData <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample(input int k);
        rec_ax[k] = wallAddrX;
        rec_ay[k] = wallAddrY;
        rec_en[k] = wallRdEn;
        rec_sd[k] = stepDone;
        rec_bz[k] = busy;
        rec_cm[k] = {canMoveL, canMoveD, canMoveR, canMoveU};
        rec_px[k] = ghostPosX;
        rec_py[k] = ghostPosY;
    endtask

    // One full query+step starting in the current cycle (cycle 0), ending in cycle 7.
    task automatic do_step(input logic [1:0] d);
        dirToMove = d;
        moveTick  = 1'b1;
        sample(0);
        for (int k = 1; k <= 7; k++) begin
            cycle();
            if (k == 1) moveTick = 1'b0;
            sample(k);
        end
    endtask

    task automatic walk(input logic [1:0] d, input int n);
        for (int i = 0; i < n; i++) do_step(d);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] sd_vec;
        for (int y = 0; y < 31; y++)
            for (int x = 0; x < 28; x++)
                maze[y][x] = 1'b0;

        // Reset state
        cycle(); cycle();
        check("rst_pos", {ghostPosX, ghostPosY}, {5'd13, 5'd11});
        check("rst_cm", {canMoveL, canMoveD, canMoveR, canMoveU}, 4'b0000);
        check("rst_busy_sd_en", {busy, stepDone, wallRdEn}, 3'b000);
        check("rst_addr", {wallAddrX, wallAddrY}, 10'd0);
        reset = 1'b1;
        cycle();

        // Open cross at (13,11), lastDir L, move L
        do_step(2'd3);
        check("x_busy1", rec_bz[1], 1'b1);
        check("x_addrU", {rec_en[1], rec_ax[1], rec_ay[1]}, {1'b1, 5'd13, 5'd10});
        check("x_addrR", {rec_en[2], rec_ax[2], rec_ay[2]}, {1'b1, 5'd14, 5'd11});
        check("x_addrD", {rec_en[3], rec_ax[3], rec_ay[3]}, {1'b1, 5'd13, 5'd12});
        check("x_addrL", {rec_en[4], rec_ax[4], rec_ay[4]}, {1'b1, 5'd12, 5'd11});
        check("x_last_idle_bus", {rec_en[5], rec_ax[5], rec_ay[5]}, 11'd0);
        check("x_cm_before", rec_cm[5], 4'b0000);
        check("x_cm", rec_cm[6], 4'b1101);
        check("x_sd", {rec_sd[5], rec_sd[6], rec_sd[7]}, 3'b010);
        check("x_pos6", {rec_px[6], rec_py[6]}, {5'd13, 5'd11});
        check("x_pos7", {rec_px[7], rec_py[7]}, {5'd12, 5'd11});
        check("x_cm_hold", rec_cm[7], 4'b1101);
        check("x_busy7", rec_bz[7], 1'b0);

        // Travel to (0,14) then take the tunnel
        walk(2'd2, 3);
        walk(2'd3, 12);
        check("walk_pos_0_14", {ghostPosX, ghostPosY}, {5'd0, 5'd14});
        do_step(2'd3);
        check("tun_addrL", {rec_en[4], rec_ax[4], rec_ay[4]}, {1'b1, 5'd27, 5'd14});
        check("tun_cm", rec_cm[6], 4'b1101);
        check("tun_pos", {rec_px[7], rec_py[7]}, {5'd27, 5'd14});

        // Dead end at (5,5): walls above, below and left
        walk(2'd0, 9);
        maze[4][5] = 1'b1;
        maze[6][5] = 1'b1;
        maze[5][4] = 1'b1;
        walk(2'd3, 22);
        check("walk_pos_5_5", {ghostPosX, ghostPosY}, {5'd5, 5'd5});
        do_step(2'd1);
        check("dead_cm", rec_cm[6], 4'b0010);
        check("dead_pos", {rec_px[7], rec_py[7]}, {5'd6, 5'd5});
        // lastDir now R: L is the reverse and is masked
        do_step(2'd0);
        check("dead_lastdir_mask", rec_cm[6], 4'b0111);
        check("dead_pos2", {rec_px[7], rec_py[7]}, {5'd6, 5'd4});

        // Left edge on a non-tunnel row: (0,3)
        do_step(2'd0);
        walk(2'd3, 6);
        check("walk_pos_0_3", {ghostPosX, ghostPosY}, {5'd0, 5'd3});
        do_step(2'd3);
        check("edge_addrL", {rec_en[4], rec_ax[4], rec_ay[4]}, {1'b1, 5'd0, 5'd3});
        check("edge_cm", rec_cm[6], 4'b0101);
        check("edge_sd", rec_sd[6], 1'b1);
        check("edge_pos", {rec_px[7], rec_py[7]}, {5'd0, 5'd3});

        // Ticks at cycles 0, 3, 7: second is dropped, third is back-to-back
        dirToMove = 2'd0;
        sd_vec = 16'd0;
        for (int c = 0; c < 16; c++) begin
            moveTick = (c == 0 || c == 3 || c == 7) ? 1'b1 : 1'b0;
            sd_vec[c] = stepDone;
            cycle();
        end
        moveTick = 1'b0;
        check("b2b_sd_pattern", sd_vec, 16'h2040);
        check("b2b_pos", {ghostPosX, ghostPosY}, {5'd0, 5'd1});

        // Reset asserted in cycle 3 of a query
        moveTick = 1'b1;
        cycle();
        moveTick = 1'b0;
        cycle();
        cycle();
        check("mid_busy_pre", busy, 1'b1);
        reset = 1'b0;
        #1;
        check("mid_busy", busy, 1'b0);
        check("mid_pos", {ghostPosX, ghostPosY}, {5'd13, 5'd11});
        check("mid_cm", {canMoveL, canMoveD, canMoveR, canMoveU}, 4'b0000);
        check("mid_sd_en", {stepDone, wallRdEn}, 2'b00);
        sd_vec = 16'd0;
        for (int c = 0; c < 6; c++) begin
            cycle();
            sd_vec[c] = stepDone | busy;
        end
        check("mid_quiet", sd_vec, 16'd0);

        // Deassert; a tick on the first following edge is accepted
        reset = 1'b1;
        do_step(2'd3);
        check("rel_addrU", {rec_en[1], rec_ax[1], rec_ay[1]}, {1'b1, 5'd13, 5'd10});
        check("rel_sd", rec_sd[6], 1'b1);
        check("rel_pos", {rec_px[7], rec_py[7]}, {5'd12, 5'd11});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ghost_mover.md
GHOST_MOVER -- requirements
Module: ghost_mover

Interface
REQ-001 SHALL have parameters, one per line: name, default, meaning:
- START_X, 13, reset tile column.
- START_Y, 11, reset tile row.
- START_DIR, 2'd3, reset heading (Left).
- TUNNEL_ROW, 14, row with horizontal wrap.
REQ-002 SHALL have ports, one per line: name, direction, width, meaning:
- clk, in, 1, single clock; all state on rising edge.
- reset, in, 1, asynchronous active-low reset (asserted at 0).
- moveTick, in, 1, one-cycle step request.
- dirToMove, in, 2, direction chosen by ghost_behavior (00 U, 01 R, 10 D, 11 L).
- wallRdEn, out, 1, maze wall read strobe.
- wallAddrX, out, 5, wall read column.
- wallAddrY, out, 5, wall read row.
- wallData, in, 1, 1 = wall; valid the cycle after wallRdEn.
- canMoveU / canMoveR / canMoveD / canMoveL, out, 1 each, registered move permissions to ghost_behavior.
- ghostPosX, out, 5, current column 0..27.
- ghostPosY, out, 5, current row 0..30.
- busy, out, 1, high whenever state != IDLE.
- stepDone, out, 1, one-cycle pulse on the step cycle.

Function
REQ-003 SHALL implement FSM states IDLE, RD_U, RD_R, RD_D, RD_L, LAST, STEP.
REQ-004 IDLE SHALL go to RD_U on moveTick=1; otherwise stay in IDLE.
REQ-005 RD_U, RD_R, RD_D, RD_L SHALL each last 1 cycle, drive wallRdEn=1 and the neighbour tile address (U: y-1, R: x+1, D: y+1, L: x-1), then advance in that order to LAST.
REQ-006 Wall data SHALL be captured into shadow bits one cycle after each read: U in RD_R, R in RD_D, D in RD_L, L in LAST.
REQ-007 Out-of-range neighbours SHALL be treated as walls; wallRdEn stays 1, the address is clamped, and wallData is ignored.
REQ-008 On TUNNEL_ROW only: L at x=0 SHALL read x=27, and R at x=27 SHALL read x=0.
REQ-009 At the end of LAST, all four canMove outputs SHALL update together as the inverse of the shadow wall bits, with the reverse of lastDir masked to 0 unless it is the only open direction.
REQ-010 STEP SHALL last 1 cycle: stepDone=1; dirToMove is sampled.
- If the matching canMove flag is 1: position moves one tile at the end of STEP (with tunnel wrap) and lastDir<=dirToMove.
- Otherwise: position and lastDir are unchanged.
- Next state: IDLE.
REQ-011 Latency SHALL be fixed: moveTick sampled in cycle 0 -> stepDone high in cycle 6 -> new position visible in cycle 7.
REQ-012 moveTick SHALL be ignored while busy=1 (no queuing).
REQ-013 A moveTick in the cycle after STEP SHALL be accepted normally (back-to-back steps every 7 cycles).
REQ-014 canMove outputs SHALL be held between queries (stable throughout STEP and IDLE).
REQ-015 Outside the RD_* states, wallRdEn SHALL be 0 and wallAddrX/Y SHALL be 0.

Reset
REQ-016 On reset=0 (asynchronous), the following SHALL take effect immediately, including mid-query:
- state=IDLE
- ghostPosX=START_X, ghostPosY=START_Y
- lastDir=START_DIR
- canMoveU/R/D/L=0, shadow bits=0
- busy=0, stepDone=0, wallRdEn=0
REQ-017 Deassertion SHALL be the only synchronous element; the first moveTick is accepted on the first clock edge after deassertion.

Structure
REQ-018 Package ghost_pkg SHALL hold: dir_t enum (DIR_U=0, DIR_R=1, DIR_D=2, DIR_L=3), MAZE_W=28, MAZE_H=31, coordinate width 5, and the state enum.
REQ-019 One combinational sub-module, tile_neighbor (inputs: coordinate, direction, tunnel row; outputs: neighbour coordinate, inRange), SHALL be used for both read addressing and the STEP update.

Verification
REQ-020 Bench SHALL cover these directed scenarios:
- Open cross at (13,11), lastDir=L, dirToMove=L, tick at cycle 0 -> addresses (13,10),(14,11),(13,12),(12,11) in cycles 1-4; canMove 1,0,1,1 (R masked as reverse); stepDone in cycle 6; position (12,11) in cycle 7.
- Dead end at (5,5), only R open, lastDir=L -> canMoveR=1 (reverse unmasked); dirToMove=R -> (6,5), lastDir=R.
- At (0,14), lastDir=L, dirToMove=L -> L read address (27,14); position becomes (27,14).
- At (0,3) -> canMoveL=0 with no wrap; dirToMove=L -> position unchanged, stepDone still pulses.
- moveTick pulsed in cycles 0, 3, and 7 -> exactly two stepDone pulses (cycles 6 and 13).
- reset=0 in cycle 3 of a query -> same-cycle IDLE, position (13,11), canMove=0000, no stepDone.
